// File: rtl/apb_two_slave_master.sv
// apb_two_slave_master
//   APB master bridge. It turns driver-side transfer requests into APB
//   SETUP/ACCESS cycles toward two slaves. Address bit AW-1 picks the slave.
//   Wait states are honoured through pready. A transfer whose slave stays
//   unready for TIMEOUT ACCESS cycles is aborted, and a one-cycle pslverr
//   pulse marks the abort.
//
// Ports
//   pclk, presetn         : APB clock, asynchronous active-low reset
//   transfer, read_write  : request strobe and direction (1 = read)
//   apb_write_paddr/data  : write request address and data
//   apb_read_paddr        : read request address
//   apb_read_data_out     : data of the last completed read
//   psel1, psel2          : slave selects (paddr MSB 0 -> slave 1, 1 -> slave 2)
//   penable, pwrite       : APB enable (ACCESS phase) and direction (1 = write)
//   paddr, pwdata         : APB address and write data
//   prdata1/2, pready1/2  : slave read data and ready
//   pslverr               : one-cycle pulse when a transfer times out
module apb_two_slave_master #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out,
  output logic          psel1,
  output logic          psel2,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata1,
  input  logic [DW-1:0] prdata2,
  input  logic          pready1,
  input  logic          pready2,
  output logic          pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pslverr_q, pslverr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          capture;
  logic          sel_ready;
  logic [DW-1:0] sel_rdata;

  // The registered address MSB picks the slave for the whole transfer, so the
  // unselected slave's ready and data never influence it.
  assign sel_ready = paddr_q[AW-1] ? pready2 : pready1;
  assign sel_rdata = paddr_q[AW-1] ? prdata2 : prdata1;

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    pslverr_d = 1'b0;
    cnt_d     = cnt_q;
    capture   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          cnt_d = '0;
          if (!pwrite_q) rdata_d = sel_rdata;
          if (transfer) begin
            capture = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // The counter holds the number of unready cycles seen so far. The
          // abort therefore lands on the TIMEOUT-th unready ACCESS cycle.
          pslverr_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request fields are captured only when a new transfer starts. A read
    // leaves the previous write data on pwdata.
    if (capture) begin
      pwrite_d = ~read_write;
      paddr_d  = read_write ? apb_read_paddr : apb_write_paddr;
      if (!read_write) pwdata_d = apb_write_data;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      pslverr_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      pslverr_q <= pslverr_d;
      cnt_q     <= cnt_d;
    end
  end

  // The selects and enable decode directly from the state register. Reset
  // clears the state asynchronously, so the bus drops to idle immediately.
  assign psel1             = (state_q != ST_IDLE) && !paddr_q[AW-1];
  assign psel2             = (state_q != ST_IDLE) &&  paddr_q[AW-1];
  assign penable           = (state_q == ST_ACCESS);
  assign pwrite            = pwrite_q;
  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign pslverr           = pslverr_q;

endmodule

// File: tb/tb_apb_two_slave_master.sv
// tb_apb_two_slave_master
//   Self-checking bench for apb_two_slave_master. The expected bus is built
//   from a transaction-level model: the last captured request (direction,
//   address and write data) and the last completed read data. The slave is
//   selected from the address MSB.
module tb_apb_two_slave_master;

  localparam int AW      = 9;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic          pclk;
  logic          presetn;
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;
  logic          psel1, psel2, penable, pwrite, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata1, prdata2;
  logic          pready1, pready2;

  int checks   = 0;
  int failures = 0;

  logic          exp_pwrite;
  logic [AW-1:0] exp_paddr;
  logic [DW-1:0] exp_pwdata;
  logic [DW-1:0] exp_rdata;

  logic [21:0] bus_obs;
  assign bus_obs = {psel1, psel2, penable, pwrite, pslverr, paddr, pwdata};

  apb_two_slave_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out),
    .psel1             (psel1),
    .psel2             (psel2),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .prdata1           (prdata1),
    .prdata2           (prdata2),
    .pready1           (pready1),
    .pready2           (pready2),
    .pslverr           (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Expected bus value from the model: selects follow the captured address MSB
  function automatic logic [21:0] bus_exp(input bit active, input bit enable, input bit err);
    return {active & ~exp_paddr[AW-1], active & exp_paddr[AW-1], enable, exp_pwrite, err,
            exp_paddr, exp_pwdata};
  endfunction

  // Drive a request and record what the bridge must capture from it
  task automatic request(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    transfer   = 1'b1;
    read_write = rw;
    if (rw) begin
      apb_read_paddr  = addr;
      apb_write_paddr = ~addr;
    end else begin
      apb_write_paddr = addr;
      apb_read_paddr  = ~addr;
    end
    apb_write_data = wd;
    exp_pwrite = !rw;
    exp_paddr  = addr;
    if (!rw) exp_pwdata = wd;
  endtask

  // Garbage on the request inputs while they must be ignored
  task automatic scramble();
    transfer        = 1'b0;
    read_write      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
    prdata1 = '0; prdata2 = '0; pready1 = 1'b0; pready2 = 1'b0;
    exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0; exp_rdata = '0;
    #1;
    checks++;
    if (bus_obs !== 22'd0) begin
      failures++; $display("[TB] FAIL reset_bus: got %h expected %h", bus_obs, 22'd0);
    end
    checks++;
    if (apb_read_data_out !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_rdata: got %h expected %h", apb_read_data_out, 8'd0);
    end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus_obs !== bus_exp(0, 0, 0)) begin
      failures++; $display("[TB] FAIL reset_release_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
    end
  endtask

  task automatic test_write();
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    for (int n = 0; n < 6; n++) begin
      addr = (n == 0) ? 9'h005 : AW'($urandom);
      d    = (n == 0) ? 8'hA5  : DW'($urandom);
      request(1'b0, addr, d);
      pready1 = ~addr[AW-1]; pready2 = addr[AW-1];
      prdata1 = DW'($urandom); prdata2 = DW'($urandom);
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL write_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 1, 0)) begin
        failures++; $display("[TB] FAIL write_access: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
      end
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(0, 0, 0)) begin
        failures++; $display("[TB] FAIL write_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
      end
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL write_rdata_held: got %h expected %h", apb_read_data_out, exp_rdata);
      end
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] addr;
    logic [DW-1:0] v;
    for (int n = 0; n < 6; n++) begin
      addr = (n == 0) ? 9'h105 : AW'($urandom);
      v    = (n == 0) ? 8'h3C  : DW'($urandom);
      request(1'b1, addr, DW'($urandom));
      pready1 = ~addr[AW-1]; pready2 = addr[AW-1];
      if (addr[AW-1]) begin prdata2 = v; prdata1 = ~v; end
      else begin prdata1 = v; prdata2 = ~v; end
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL read_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 1, 0)) begin
        failures++; $display("[TB] FAIL read_access: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
      end
      exp_rdata = v;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(0, 0, 0)) begin
        failures++; $display("[TB] FAIL read_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
      end
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL read_data: got %h expected %h", apb_read_data_out, exp_rdata);
      end
    end
  endtask

  task automatic test_boundary();
    logic [AW-1:0] addrs [2];
    logic [DW-1:0] v;
    addrs[0] = 9'h0FF;
    addrs[1] = 9'h100;
    for (int n = 0; n < 2; n++) begin
      v = DW'($urandom);
      request(n == 0, addrs[n], v);
      pready1 = (n == 0); pready2 = (n == 1);
      prdata1 = v; prdata2 = ~v;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL boundary_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      @(negedge pclk);
      if (n == 0) exp_rdata = v;
      @(negedge pclk);
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL boundary_rdata: got %h expected %h", apb_read_data_out, exp_rdata);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [AW-1:0] addr;
    logic [DW-1:0] v;
    int waits;
    for (int n = 0; n < 4; n++) begin
      addr  = (n == 0) ? 9'h033 : AW'($urandom);
      v     = (n == 0) ? 8'h77  : DW'($urandom);
      waits = (n == 0) ? 3 : int'($urandom_range(1, 6));
      request(1'b1, addr, DW'($urandom));
      // Unselected ready high: only the selected ready may end the transfer
      pready1 = addr[AW-1]; pready2 = ~addr[AW-1];
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL wait_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      for (int i = 0; i <= waits; i++) begin
        @(negedge pclk);
        checks++;
        if (bus_obs !== bus_exp(1, 1, 0)) begin
          failures++; $display("[TB] FAIL wait_access cycle %0d: got %h expected %h", i, bus_obs, bus_exp(1, 1, 0));
        end
        checks++;
        if (apb_read_data_out !== exp_rdata) begin
          failures++; $display("[TB] FAIL wait_rdata_early: got %h expected %h", apb_read_data_out, exp_rdata);
        end
        if (addr[AW-1]) begin
          pready2 = (i == waits); prdata2 = (i == waits) ? v : DW'($urandom); prdata1 = DW'($urandom);
        end else begin
          pready1 = (i == waits); prdata1 = (i == waits) ? v : DW'($urandom); prdata2 = DW'($urandom);
        end
      end
      exp_rdata = v;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(0, 0, 0)) begin
        failures++; $display("[TB] FAIL wait_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
      end
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL wait_rdata: got %h expected %h", apb_read_data_out, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] v;
    for (int n = 0; n < 2; n++) begin
      waddr = (n == 0) ? 9'h010 : {1'b0, 8'($urandom)};
      raddr = (n == 0) ? 9'h110 : {1'b1, 8'($urandom)};
      v     = DW'($urandom);
      request(1'b0, waddr, DW'($urandom));
      pready1 = 1'b1; pready2 = 1'b0;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL b2b_setup1: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 1, 0)) begin
        failures++; $display("[TB] FAIL b2b_access1: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
      end
      request(1'b1, raddr, DW'($urandom));
      prdata2 = v; prdata1 = ~v;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL b2b_setup2: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      pready1 = 1'b0; pready2 = 1'b1;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 1, 0)) begin
        failures++; $display("[TB] FAIL b2b_access2: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
      end
      exp_rdata = v;
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(0, 0, 0)) begin
        failures++; $display("[TB] FAIL b2b_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
      end
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL b2b_rdata: got %h expected %h", apb_read_data_out, exp_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    logic [AW-1:0] addr;
    int count;
    bit done;
    for (int n = 0; n < 2; n++) begin
      // First a write to slave 2, then a read from slave 1
      addr = (n == 0) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom)};
      request(n == 1, addr, DW'($urandom));
      pready1 = addr[AW-1]; pready2 = ~addr[AW-1];
      prdata1 = DW'($urandom); prdata2 = DW'($urandom);
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(1, 0, 0)) begin
        failures++; $display("[TB] FAIL timeout_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
      end
      scramble();
      count = 0;
      done  = 1'b0;
      for (int i = 0; i < TIMEOUT + 8 && !done; i++) begin
        @(negedge pclk);
        if (penable === 1'b1) begin
          count++;
          checks++;
          if (bus_obs !== bus_exp(1, 1, 0)) begin
            failures++; $display("[TB] FAIL timeout_access: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
          end
        end else begin
          done = 1'b1;
        end
      end
      checks++;
      if (count != TIMEOUT) begin
        failures++; $display("[TB] FAIL timeout_access_cycles: got %0d expected %0d", count, TIMEOUT);
      end
      checks++;
      if (bus_obs !== bus_exp(0, 0, 1)) begin
        failures++; $display("[TB] FAIL timeout_pslverr: got %h expected %h", bus_obs, bus_exp(0, 0, 1));
      end
      checks++;
      if (apb_read_data_out !== exp_rdata) begin
        failures++; $display("[TB] FAIL timeout_rdata: got %h expected %h", apb_read_data_out, exp_rdata);
      end
      @(negedge pclk);
      checks++;
      if (bus_obs !== bus_exp(0, 0, 0)) begin
        failures++; $display("[TB] FAIL timeout_pulse_end: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] addr;
    logic [DW-1:0] v;
    request(1'b0, {1'b0, 8'($urandom)}, DW'($urandom));
    pready1 = 1'b0; pready2 = 1'b1;
    @(negedge pclk);
    scramble();
    @(negedge pclk);
    checks++;
    if (bus_obs !== bus_exp(1, 1, 0)) begin
      failures++; $display("[TB] FAIL areset_access: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
    end
    #2 presetn = 1'b0;
    exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0; exp_rdata = '0;
    #1;
    checks++;
    if (bus_obs !== 22'd0) begin
      failures++; $display("[TB] FAIL areset_immediate: got %h expected %h", bus_obs, 22'd0);
    end
    checks++;
    if (apb_read_data_out !== 8'd0) begin
      failures++; $display("[TB] FAIL areset_rdata: got %h expected %h", apb_read_data_out, 8'd0);
    end
    pready1 = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus_obs !== bus_exp(0, 0, 0)) begin
      failures++; $display("[TB] FAIL areset_release_idle: got %h expected %h", bus_obs, bus_exp(0, 0, 0));
    end
    addr = {1'b1, 8'($urandom)};
    v    = DW'($urandom);
    request(1'b1, addr, DW'($urandom));
    pready1 = 1'b0; pready2 = 1'b1; prdata2 = v; prdata1 = ~v;
    @(negedge pclk);
    checks++;
    if (bus_obs !== bus_exp(1, 0, 0)) begin
      failures++; $display("[TB] FAIL areset_next_setup: got %h expected %h", bus_obs, bus_exp(1, 0, 0));
    end
    scramble();
    @(negedge pclk);
    checks++;
    if (bus_obs !== bus_exp(1, 1, 0)) begin
      failures++; $display("[TB] FAIL areset_next_access: got %h expected %h", bus_obs, bus_exp(1, 1, 0));
    end
    exp_rdata = v;
    @(negedge pclk);
    checks++;
    if (apb_read_data_out !== exp_rdata) begin
      failures++; $display("[TB] FAIL areset_next_rdata: got %h expected %h", apb_read_data_out, exp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_boundary();
    test_wait_states();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
